// File: rtl/combo_lock_fsm.sv
// Combination-check FSM: collects four debounced digit entries, compares them to CODE,
// then opens, raises an error, or locks out. Optional entry timeout: COMBO_LOCK_TIMEOUT_EN.
module combo_lock_fsm #(
  parameter int                   DIGIT_W        = 4,
  parameter logic [4*DIGIT_W-1:0] CODE           = 16'h1234,
  parameter int                   MAX_FAILS      = 3,
  parameter int                   UNLOCK_CYCLES  = 500_000_000,
  parameter int                   LOCKOUT_CYCLES = 1_000_000_000,
  parameter int                   TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enter,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] digit,
  output logic [1:0]         pos,
  output logic               unlocked,
  output logic               alarm,
  output logic               err,
  output logic [1:0]         fail_cnt
);

  localparam int MAX_UL    = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_MAX = (MAX_UL > TIMEOUT_CYCLES) ? MAX_UL : TIMEOUT_CYCLES;
  localparam int TW        = $clog2(longint'(TIMER_MAX) + 64'd1);

  localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    FAIL_LIMIT  = 2'(MAX_FAILS);

  // Index 3 holds the first digit entered, index 0 the last.
  localparam logic [3:0][DIGIT_W-1:0] CODE_DIGITS = CODE;

`ifdef COMBO_LOCK_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_e;

  state_e        state;
  logic          mismatch;
  logic [TW-1:0] timer;
  logic [TW-1:0] timerInc;
  logic [1:0]    failNext;
  logic          digitBad;

  // Shared timer saturates instead of wrapping.
  assign timerInc = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);
  assign failNext = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 2'd1;
  assign digitBad = (digit != CODE_DIGITS[2'd3 - pos]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENTRY;
      pos      <= 2'd0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
      err      <= 1'b0;
      fail_cnt <= 2'd0;
      mismatch <= 1'b0;
      timer    <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (clear) begin
            pos      <= 2'd0;
            mismatch <= 1'b0;
            timer    <= '0;
          end else if (enter) begin
            mismatch <= mismatch | digitBad;
            timer    <= '0;
            if (pos == 2'd3) begin
              pos   <= 2'd0;
              state <= CHECK;
            end else begin
              pos <= pos + 2'd1;
            end
          end
`ifdef COMBO_LOCK_TIMEOUT_EN
          // Inactivity discards a partial entry just like clear.
          else if (pos != 2'd0) begin
            if (timer == TIMEOUT_LAST) begin
              pos      <= 2'd0;
              mismatch <= 1'b0;
              timer    <= '0;
            end else begin
              timer <= timerInc;
            end
          end
`endif
        end
        CHECK: begin
          timer <= '0;
          if (!mismatch) begin
            state    <= OPEN;
            unlocked <= 1'b1;
            fail_cnt <= 2'd0;
          end else begin
            err      <= 1'b1;
            mismatch <= 1'b0;
            fail_cnt <= failNext;
            if (failNext == FAIL_LIMIT) begin
              state <= LOCKOUT;
              alarm <= 1'b1;
            end else begin
              state <= ENTRY;
            end
          end
        end
        OPEN: begin
          if (clear || timer == UNLOCK_LAST) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timerInc;
          end
        end
        LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            state    <= ENTRY;
            alarm    <= 1'b0;
            fail_cnt <= 2'd0;
            timer    <= '0;
          end else begin
            timer <= timerInc;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: directed plan steps then random pulses, checked every cycle
// against a digit-queue / countdown reference model.
module tb_combo_lock_fsm;
  localparam int UNLOCK  = 10;
  localparam int LOCK    = 20;
  localparam int TIMEOUT = 8;
  localparam int MAXF    = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enter, clear;
  logic [3:0] digit;
  logic [1:0] pos, fail_cnt;
  logic       unlocked, alarm, err;

  int total = 0;
  int bad   = 0;

  combo_lock_fsm #(
    .DIGIT_W(4), .CODE(16'h1234), .MAX_FAILS(MAXF),
    .UNLOCK_CYCLES(UNLOCK), .LOCKOUT_CYCLES(LOCK), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enter(enter), .clear(clear), .digit(digit),
    .pos(pos), .unlocked(unlocked), .alarm(alarm), .err(err), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: digits typed so far, remaining open/lockout cycles, failure count.
  int q[$];
  bit pendingCheck;
  int openLeft, lockLeft, fails, idleCnt;
  bit expErr;

  function automatic int codeDigit(input int i);
    logic [15:0] c;
    c = 16'h1234;
    return int'(c[(3-i)*4 +: 4]);
  endfunction

  task automatic modelReset();
    q.delete();
    pendingCheck = 0; openLeft = 0; lockLeft = 0; fails = 0; idleCnt = 0; expErr = 0;
  endtask

  task automatic modelStep(input bit en, input bit cl, input int d);
    bit match;
    expErr = 0;
    if (lockLeft > 0) begin
      lockLeft--;
      if (lockLeft == 0) fails = 0;
    end else if (openLeft > 0) begin
      if (cl) openLeft = 0;
      else openLeft--;
    end else if (pendingCheck) begin
      pendingCheck = 0;
      match = 1;
      for (int i = 0; i < 4; i++) if (q[i] != codeDigit(i)) match = 0;
      q.delete();
      if (match) begin
        openLeft = UNLOCK;
        fails = 0;
      end else begin
        expErr = 1;
        if (fails < MAXF) fails++;
        if (fails == MAXF) lockLeft = LOCK;
      end
    end else if (cl) begin
      q.delete(); idleCnt = 0;
    end else if (en) begin
      q.push_back(d); idleCnt = 0;
      if (q.size() == 4) pendingCheck = 1;
    end else if (q.size() > 0) begin
`ifdef COMBO_LOCK_TIMEOUT_EN
      idleCnt++;
      if (idleCnt == TIMEOUT) begin q.delete(); idleCnt = 0; end
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".pos"},      32'(pos),      pendingCheck ? 0 : q.size());
    chk({tag, ".unlocked"}, 32'(unlocked), (openLeft > 0) ? 1 : 0);
    chk({tag, ".alarm"},    32'(alarm),    (lockLeft > 0) ? 1 : 0);
    chk({tag, ".err"},      32'(err),      32'(expErr));
    chk({tag, ".fail_cnt"}, 32'(fail_cnt), fails);
  endtask

  // Called just after a rising edge; drives inputs, steps one edge, checks #1 later.
  task automatic tick(input bit en, input bit cl, input int d, input string tag = "cyc");
    enter = en; clear = cl; digit = 4'(d);
    @(posedge clk);
    modelStep(en, cl, d);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input int n, input string tag = "idle");
    for (int i = 0; i < n; i++) tick(0, 0, 0, tag);
  endtask

  task automatic code4(input int a, input int b, input int c, input int d, input string tag);
    tick(1, 0, a, tag); tick(1, 0, b, tag); tick(1, 0, c, tag); tick(1, 0, d, tag);
  endtask

  task automatic doReset(input string tag);
    enter = 0; clear = 0; digit = 0;
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll({tag, ".async"});
    @(posedge clk);
    #1 checkAll({tag, ".hold"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enter = 0; clear = 0; digit = 0;
    modelReset();
    #3 checkAll("reset");
    @(posedge clk);
    #1 checkAll("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Correct code, then auto-relock.
    code4(1, 2, 3, 4, "good");
    idle(14, "open_hold");

    // One wrong attempt.
    code4(1, 2, 3, 5, "wrong1");
    idle(3, "after_wrong1");

    // Two more wrong attempts reach lockout; enter is ignored while alarmed.
    code4(9, 2, 3, 4, "wrong2");
    idle(2, "after_wrong2");
    code4(1, 2, 3, 3, "wrong3");
    for (int i = 0; i < 4; i++) tick(1, 0, i + 1, "lock_enter");
    tick(0, 1, 0, "lock_clear");
    idle(18, "lockout");
    code4(1, 2, 3, 4, "good_after_lock");
    idle(12, "open2");

    // Clear wins over a simultaneous enter; clear relocks while open.
    tick(1, 0, 1, "clr_mid"); tick(1, 0, 2, "clr_mid");
    tick(1, 1, 3, "clr_with_enter");
    code4(1, 2, 3, 4, "good_after_clr");
    idle(3, "open3");
    tick(0, 1, 0, "clear_open");
    idle(2, "after_clear_open");

    // Async reset while open and while locked out.
    code4(1, 2, 3, 4, "good_rst");
    idle(3, "open_rst");
    doReset("rst_open");
    code4(1, 1, 1, 1, "w_a"); idle(1);
    code4(2, 2, 2, 2, "w_b"); idle(1);
    code4(3, 3, 3, 3, "w_c");
    idle(5, "lock_rst");
    doReset("rst_lock");

    // Partial entry then inactivity.
    tick(1, 0, 1, "to_entry"); tick(1, 0, 2, "to_entry");
    idle(TIMEOUT, "to_idle");
`ifdef COMBO_LOCK_TIMEOUT_EN
    chk("timeout_pos", 32'(pos), 0);
`else
    chk("timeout_pos", 32'(pos), 2);
`endif
    tick(0, 1, 0, "to_clear");

    // Random pulses, digits biased toward the code so every outcome occurs.
    for (int c = 0; c < 3000; c++) begin
      bit en, cl;
      int d, k;
      if ($urandom_range(599) == 0) doReset("rnd_rst");
      en = ($urandom_range(3) == 0);
      cl = ($urandom_range(19) == 0);
      k  = (q.size() > 3) ? 3 : q.size();
      d  = ($urandom_range(9) < 7) ? codeDigit(k) : int'($urandom_range(15));
      tick(en, cl, d, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
